// File: rtl/internal_paths_pipe.sv
// internal_paths_pipe
//   Registered tapped pipeline for timing-path characterisation. A launch
//   register s[0] feeds DEPTH stages s[1..DEPTH]; NTAPS capture registers
//   sample programmable stages, one timing path group per tap.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid, in    input qualifier and data
//   en              advance; 0 holds everything (valid input is dropped)
//   flush           with en=1: clears all stage/tap valids, input discarded
//   sel             combinational output tap select
//   out, out_valid  selected tap data/valid (0 for sel >= NTAPS)
//   taps, taps_valid  all capture registers, tap k at [WIDTH*k +: WIDTH]
//   occupancy       popcount of stage valids v[0..DEPTH]
//   drop_cnt        saturating count of inputs dropped while en=0
module internal_paths_pipe #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 6,
  parameter int                 NTAPS   = 5,
  parameter logic [NTAPS*8-1:0] TAP_POS = {8'd6, 8'd4, 8'd3, 8'd2, 8'd1},
  parameter int                 SELW    = 3,
  parameter int                 CW      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in,
  input  logic                   en,
  input  logic                   flush,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [NTAPS*WIDTH-1:0] taps,
  output logic [NTAPS-1:0]       taps_valid,
  output logic [CW-1:0]          occupancy,
  output logic [7:0]             drop_cnt
);

  logic [DEPTH:0][WIDTH-1:0] s_q, s_d;
  logic [DEPTH:0]            v_q, v_d;
  logic [NTAPS-1:0][WIDTH-1:0] tap_q, tap_d;
  logic [NTAPS-1:0]          tv_q, tv_d;
  logic [7:0]                drop_q, drop_d;

  // Tap source selection is fixed at elaboration, so each capture register
  // sees a plain wire from its stage.
  logic [NTAPS-1:0][WIDTH-1:0] tap_src;
  logic [NTAPS-1:0]            tap_src_v;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    localparam int P = int'(TAP_POS[8*k +: 8]);
    assign tap_src[k]   = s_q[P];
    assign tap_src_v[k] = v_q[P];
  end

  always_comb begin
    s_d    = s_q;
    v_d    = v_q;
    tap_d  = tap_q;
    tv_d   = tv_q;
    drop_d = drop_q;
    if (en) begin
      if (flush) begin
        // Data is left in place; only the valids matter after a flush.
        v_d  = '0;
        tv_d = '0;
      end else begin
        s_d   = {s_q[DEPTH-1:0], in};
        v_d   = {v_q[DEPTH-1:0], in_valid};
        tap_d = tap_src;
        tv_d  = tap_src_v;
      end
    end else if (in_valid && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      v_q    <= '0;
      tap_q  <= '0;
      tv_q   <= '0;
      drop_q <= '0;
    end else begin
      s_q    <= s_d;
      v_q    <= v_d;
      tap_q  <= tap_d;
      tv_q   <= tv_d;
      drop_q <= drop_d;
    end
  end

  // Output mux; indices with no tap behind them read as zero.
  always_comb begin
    out       = '0;
    out_valid = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      if (sel == SELW'(k)) begin
        out       = tap_q[k];
        out_valid = tv_q[k];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i <= DEPTH; i++) occupancy = occupancy + CW'(v_q[i]);
  end

  assign taps       = tap_q;
  assign taps_valid = tv_q;
  assign drop_cnt   = drop_q;

endmodule
